// File: rtl/vram_pkg.sv
// Shared encodings for the VRAM access sequencer: command codes, FSM states,
// and the command decode used at request accept.
package vram_pkg;

    localparam logic [1:0] CMD_RD   = 2'd0;
    localparam logic [1:0] CMD_WR   = 2'd1;
    localparam logic [1:0] CMD_XFER = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COL  = 3'd2,
        ST_XEND = 3'd3,
        ST_PRE  = 3'd4
    } vram_state_e;

    // The reserved code behaves exactly like a read.
    function automatic logic [1:0] decode_cmd(input logic [1:0] cmd);
        return ((cmd == CMD_WR) || (cmd == CMD_XFER)) ? cmd : CMD_RD;
    endfunction

endpackage

// File: rtl/vram_ser_step.sv
// Serial port stepper: on an accepted step it captures the current serial
// byte and raises SC for exactly one cycle, so steps come at most every
// other cycle. 'block' holds off steps while the serial register reloads.
module vram_ser_step (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       block,
    input  logic [7:0] sd_i,
    output logic       sc,
    output logic [7:0] sdata,
    output logic       busy
);

    logic       sc_q, sc_d;
    logic [7:0] sdata_q, sdata_d;
    logic       accept;

    assign busy  = sc_q | block;
    assign sc    = sc_q;
    assign sdata = sdata_q;

    // Accept a step only when SC is low and no reload window is open.
    always_comb begin
        accept  = step & ~busy;
        sc_d    = accept;
        sdata_d = accept ? sd_i : sdata_q;
    end

    // Stepper registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q    <= 1'b0;
            sdata_q <= 8'h00;
        end else begin
            sc_q    <= sc_d;
            sdata_q <= sdata_d;
        end
    end

endmodule

// File: rtl/vram_seq.sv
// VRAM access sequencer: turns single-cycle read/write/read-transfer
// requests into registered RAS/CAS/WE/OE strobes with row/column muxing on
// AD, and hosts the serial stepper. One down-counter times every state;
// it is loaded with (cycles - 1) on state entry and the state exits at 0.
module vram_seq
    import vram_pkg::*;
#(
    parameter int T_RCD = 1,
    parameter int T_CAS = 3,
    parameter int T_RP  = 2
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        REQ,
    input  logic [1:0]  CMD,
    input  logic [15:0] ADDR,
    input  logic [7:0]  WDATA,
    output logic        BUSY,
    output logic        ACK,
    output logic [7:0]  RDATA,
    input  logic        SER_STEP,
    input  logic        SER_EN,
    output logic        SER_BUSY,
    output logic [7:0]  SDATA,
    output logic        RAS,
    output logic        CAS,
    output logic        WE,
    output logic        OE,
    output logic        SC,
    output logic        SE,
    output logic [7:0]  AD,
    output logic [7:0]  RD_o,
    output logic        RD_d,
    input  logic [7:0]  RD_i,
    input  logic [7:0]  SD_i,
    output vram_state_e DBG_STATE
);

    localparam logic [7:0] LD_RCD = 8'(T_RCD - 1);
    localparam logic [7:0] LD_CAS = 8'(T_CAS - 1);
    localparam logic [7:0] LD_RP  = 8'(T_RP - 1);

    vram_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ras_q, ras_d, cas_q, cas_d, we_q, we_d, oe_q, oe_d;
    logic [7:0]  ad_q, ad_d, rd_o_q, rd_o_d, rdata_q, rdata_d;
    logic        rd_d_q, rd_d_d, ack_q, ack_d, se_q;
    logic        ser_block;

    // Next state, timing counter, and request latch on accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    state_d = ST_ROW;
                    cnt_d   = LD_RCD;
                    cmd_d   = decode_cmd(CMD);
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                end
            end
            ST_ROW: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_COL;
                    cnt_d   = LD_CAS;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_COL: begin
                if (cnt_q == 8'd0) begin
                    if (cmd_q == CMD_XFER) begin
                        state_d = ST_XEND;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = LD_RP;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_XEND: begin
                state_d = ST_PRE;
                cnt_d   = LD_RP;
            end
            ST_PRE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_PRE;
                cnt_d   = LD_RP;
            end
        endcase
    end

    // Strobe/bus values for the coming cycle, derived from the next state so
    // every pin is a flop output. WE waits for the second COL cycle because
    // the VRAM latches the column one edge after CAS falls.
    always_comb begin
        ras_d   = 1'b1;
        cas_d   = 1'b1;
        we_d    = 1'b1;
        oe_d    = 1'b1;
        ad_d    = 8'h00;
        rd_o_d  = rd_o_q;
        rd_d_d  = 1'b0;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_d)
            ST_ROW: begin
                ras_d = 1'b0;
                ad_d  = addr_d[15:8];
                oe_d  = (cmd_d != CMD_XFER);
            end
            ST_COL: begin
                ras_d = 1'b0;
                cas_d = 1'b0;
                ad_d  = addr_d[7:0];
                if (cmd_d == CMD_WR) begin
                    oe_d   = 1'b1;
                    rd_o_d = wdata_d;
                    rd_d_d = 1'b1;
                    we_d   = (state_q != ST_COL);
                end else begin
                    oe_d = 1'b0;
                end
            end
            ST_XEND: begin
                ras_d = 1'b0;
                cas_d = 1'b0;
                ad_d  = addr_d[7:0];
            end
            ST_PRE: begin
                ack_d = (state_q != ST_PRE);
            end
            default: ;
        endcase
        if ((state_q == ST_COL) && (cnt_q == 8'd0) && (cmd_q == CMD_RD)) begin
            rdata_d = RD_i;
        end
    end

    // Sequencer registers; reset parks in PRE so the VRAM sees a full precharge.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_PRE;
            cnt_q   <= LD_RP;
            cmd_q   <= CMD_RD;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            ras_q   <= 1'b1;
            cas_q   <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            ad_q    <= 8'h00;
            rd_o_q  <= 8'h00;
            rd_d_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
            se_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ras_q   <= ras_d;
            cas_q   <= cas_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            ad_q    <= ad_d;
            rd_o_q  <= rd_o_d;
            rd_d_q  <= rd_d_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            se_q    <= ~SER_EN;
        end
    end

    // Serial steps must not race the reload: hold them off in XEND and in the
    // first PRE cycle after a transfer (ACK marks that first PRE cycle).
    assign ser_block = (state_q == ST_XEND) ||
                       ((state_q == ST_PRE) && ack_q && (cmd_q == CMD_XFER));

    vram_ser_step u_ser_step (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .step  (SER_STEP),
        .block (ser_block),
        .sd_i  (SD_i),
        .sc    (SC),
        .sdata (SDATA),
        .busy  (SER_BUSY)
    );

    assign BUSY      = (state_q != ST_IDLE);
    assign ACK       = ack_q;
    assign RDATA     = rdata_q;
    assign RAS       = ras_q;
    assign CAS       = cas_q;
    assign WE        = we_q;
    assign OE        = oe_q;
    assign SE        = se_q;
    assign AD        = ad_q;
    assign RD_o      = rd_o_q;
    assign RD_d      = rd_d_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_vram_seq.sv
// Bench for vram_seq: a behavioural dual-port VRAM model on the main
// instance, plus a second instance with stretched ROW/COL timing.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_vram_seq;
    import vram_pkg::*;

    logic        mclk, reset_n;
    logic        req, ser_step, ser_en;
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy, ack, ser_busy, ras, cas, we, oe, sc, se, rd_d;
    logic [7:0]  rdata, sdata, ad, rd_o, rd_i, sd_i;
    vram_state_e dbg_state;

    logic        req2, ser_step2, ser_en2;
    logic [1:0]  cmd2;
    logic [15:0] addr2;
    logic [7:0]  wdata2, rd_i2, sd_i2;
    logic        busy2, ack2, ser_busy2, ras2, cas2, we2, oe2, sc2, se2, rd_d2;
    logic [7:0]  rdata2, sdata2, ad2, rd_o2;
    vram_state_e dbg_state2;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    vram_seq u_dut (
        .MCLK(mclk), .RESET_N(reset_n), .REQ(req), .CMD(cmd), .ADDR(addr),
        .WDATA(wdata), .BUSY(busy), .ACK(ack), .RDATA(rdata),
        .SER_STEP(ser_step), .SER_EN(ser_en), .SER_BUSY(ser_busy), .SDATA(sdata),
        .RAS(ras), .CAS(cas), .WE(we), .OE(oe), .SC(sc), .SE(se), .AD(ad),
        .RD_o(rd_o), .RD_d(rd_d), .RD_i(rd_i), .SD_i(sd_i), .DBG_STATE(dbg_state)
    );

    vram_seq #(.T_RCD(2), .T_CAS(4), .T_RP(2)) u_dut_slow (
        .MCLK(mclk), .RESET_N(reset_n), .REQ(req2), .CMD(cmd2), .ADDR(addr2),
        .WDATA(wdata2), .BUSY(busy2), .ACK(ack2), .RDATA(rdata2),
        .SER_STEP(ser_step2), .SER_EN(ser_en2), .SER_BUSY(ser_busy2), .SDATA(sdata2),
        .RAS(ras2), .CAS(cas2), .WE(we2), .OE(oe2), .SC(sc2), .SE(se2), .AD(ad2),
        .RD_o(rd_o2), .RD_d(rd_d2), .RD_i(rd_i2), .SD_i(sd_i2), .DBG_STATE(dbg_state2)
    );

    // ---------------- clock ----------------
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // ---------------- VRAM model ----------------
    // Strobes are sampled at each rising edge (pre-update values = the cycle
    // just ended). Untouched bytes hold addr[7:0] ^ addr[15:8].
    logic [7:0] mem [0:65535];
    bit         mem_ready = 1'b0;
    logic       m_ras_p = 1'b1, m_cas_p = 1'b1, m_oe_p = 1'b1, m_sc_p = 1'b0;
    logic       m_xfer = 1'b0;
    logic [7:0] m_row = 8'h00, m_col = 8'h00, s_row = 8'h00, s_ptr = 8'h00;

    always @(posedge mclk) begin
        if (!reset_n) begin
            m_ras_p <= 1'b1;
            m_cas_p <= 1'b1;
            m_oe_p  <= 1'b1;
            m_sc_p  <= 1'b0;
            m_xfer  <= 1'b0;
            if (!mem_ready) begin
                for (int i = 0; i < 65536; i++) mem[i] <= 8'(i[7:0] ^ i[15:8]);
                mem_ready <= 1'b1;
            end
        end else begin
            m_ras_p <= ras;
            m_cas_p <= cas;
            m_oe_p  <= oe;
            m_sc_p  <= sc;
            if (!ras && m_ras_p) begin
                m_row  <= ad;
                m_xfer <= !oe;
            end
            if (!ras && !cas && m_cas_p) m_col <= ad;
            if (!ras && !cas && !we && rd_d) mem[{m_row, m_col}] <= rd_o;
            if (!ras && m_xfer && oe && !m_oe_p) begin
                s_row <= m_row;
                s_ptr <= m_col;
            end else if (sc && !m_sc_p) begin
                s_ptr <= s_ptr + 8'd1;
            end
        end
    end

    assign rd_i = mem[{m_row, m_col}];
    assign sd_i = mem[{s_row, s_ptr}];

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one access; sample k = 0 is taken just after the accept edge.
    task automatic run_access(input logic [1:0] c, input logic [15:0] a, input logic [7:0] d,
                              output int ack_at, output int we_low, output int idle_at,
                              output logic [7:0] ad_row, output logic [7:0] ad_col);
        wait_idle();
        req = 1'b1; cmd = c; addr = a; wdata = d;
        tick();
        req = 1'b0;
        ack_at = -1; we_low = 0; idle_at = -1; ad_row = 8'h00; ad_col = 8'h00;
        for (int k = 0; k < 12; k++) begin
            if (ack && ack_at < 0) ack_at = k;
            if (!we) we_low++;
            if (!busy && idle_at < 0) idle_at = k;
            if (k == 0) ad_row = ad;
            if (k == 1) ad_col = ad;
            tick();
        end
    endtask

    task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
        int ack_at, we_low, idle_at;
        logic [7:0] r, c;
        run_access(CMD_WR, a, d, ack_at, we_low, idle_at, r, c);
        check("wr_ack_at", 32'(ack_at), 32'd4);
        check("wr_we_low", 32'(we_low), 32'd2);
    endtask

    task automatic read_expect(input string tag, input logic [15:0] a, input logic [7:0] e);
        int ack_at, we_low, idle_at;
        logic [7:0] r, c;
        exp_q.push_back(e);
        run_access(CMD_RD, a, 8'h00, ack_at, we_low, idle_at, r, c);
        check({tag, "_ack_at"}, 32'(ack_at), 32'd4);
        check({tag, "_data"}, 32'(rdata), 32'(exp_q.pop_front()));
    endtask

    task automatic step_expect(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        ser_step = 1'b1;
        tick();
        ser_step = 1'b0;
        check({tag, "_sc"}, 32'(sc), 32'd1);
        check(tag, 32'(sdata), 32'(exp_q.pop_front()));
        tick();
    endtask

    // ---------------- stimulus ----------------
    int         ack_at, we_low, idle_at, acc_n, low_between;
    int         acc_t[3];
    logic [7:0] ad_row, ad_col;
    logic       pb;
    logic       sc_s[10], sb_s[10];

    initial begin
        reset_n = 1'b0; req = 1'b0; cmd = 2'd0; addr = 16'h0; wdata = 8'h0;
        ser_step = 1'b0; ser_en = 1'b0;
        req2 = 1'b0; cmd2 = 2'd0; addr2 = 16'h0; wdata2 = 8'h0; rd_i2 = 8'h00;
        sd_i2 = 8'h00; ser_step2 = 1'b0; ser_en2 = 1'b0;
        repeat (3) @(posedge mclk);
        #1;

        // Reset values
        check("rst_ras", 32'(ras), 32'd1);
        check("rst_cas", 32'(cas), 32'd1);
        check("rst_we", 32'(we), 32'd1);
        check("rst_oe", 32'(oe), 32'd1);
        check("rst_se", 32'(se), 32'd1);
        check("rst_sc", 32'(sc), 32'd0);
        check("rst_ad", 32'(ad), 32'd0);
        check("rst_rd_o", 32'(rd_o), 32'd0);
        check("rst_rd_d", 32'(rd_d), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_ser_busy", 32'(ser_busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(negedge mclk);
        reset_n = 1'b1;
        tick();
        check("rel_busy_1", 32'(busy), 32'd1);
        tick();
        check("rel_busy_2", 32'(busy), 32'd0);

        // SE follows the inverted enable one edge later
        ser_en = 1'b1;
        tick();
        check("se_on", 32'(se), 32'd0);
        ser_en = 1'b0;
        tick();
        check("se_off", 32'(se), 32'd1);

        // Write 0x5A to 0x1234 and read it back
        run_access(CMD_WR, 16'h1234, 8'h5A, ack_at, we_low, idle_at, ad_row, ad_col);
        check("w1_ad_row", 32'(ad_row), 32'h12);
        check("w1_ad_col", 32'(ad_col), 32'h34);
        check("w1_we_low", 32'(we_low), 32'd2);
        check("w1_ack_at", 32'(ack_at), 32'd4);
        check("w1_idle_at", 32'(idle_at), 32'd6);
        read_expect("r1", 16'h1234, 8'h5A);

        // Serial transfer from pointer 1 of row 0x02
        write_byte(16'h0200, 8'h11);
        write_byte(16'h0201, 8'h22);
        write_byte(16'h0202, 8'h33);
        write_byte(16'h0203, 8'h44);
        run_access(CMD_XFER, 16'h0201, 8'h00, ack_at, we_low, idle_at, ad_row, ad_col);
        check("x_ack_at", 32'(ack_at), 32'd5);
        check("x_idle_at", 32'(idle_at), 32'd7);
        check("x_we_low", 32'(we_low), 32'd0);
        step_expect("step0", 8'h22);
        step_expect("step1", 8'h33);
        step_expect("step2", 8'h44);
        step_expect("step3", 8'h06);

        // Back-to-back reads with REQ held: one ROW + three COL + two PRE
        // cycles, then a single idle cycle before the next accept edge.
        wait_idle();
        req = 1'b1; cmd = CMD_RD; addr = 16'h1234;
        acc_n = 0; low_between = 0;
        for (int t = 0; t < 30; t++) begin
            pb = busy;
            tick();
            if (!pb && busy) begin
                if (acc_n < 3) acc_t[acc_n] = t;
                acc_n++;
                if (acc_n == 3) req = 1'b0;
            end else if (!busy && acc_n >= 1 && acc_n < 3) begin
                low_between++;
            end
        end
        check("b2b_accepts", 32'(acc_n), 32'd3);
        check("b2b_gap_1", 32'(acc_t[1] - acc_t[0]), 32'd7);
        check("b2b_gap_2", 32'(acc_t[2] - acc_t[1]), 32'd7);
        check("b2b_idle_cycles", 32'(low_between), 32'd2);
        check("b2b_rdata", 32'(rdata), 32'h5A);

        // SER_STEP held through a transfer: SC alternates, except that the
        // XEND cycle and the cycle after it see no new step.
        wait_idle();
        req = 1'b1; cmd = CMD_XFER; addr = 16'h0300;
        tick();
        req = 1'b0;
        ser_step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sc_s[k] = sc;
            sb_s[k] = ser_busy;
            tick();
        end
        ser_step = 1'b0;
        check("hold_sc_k0", 32'(sc_s[0]), 32'd0);
        check("hold_sc_k1", 32'(sc_s[1]), 32'd1);
        check("hold_sc_k2", 32'(sc_s[2]), 32'd0);
        check("hold_sc_k3", 32'(sc_s[3]), 32'd1);
        check("hold_sc_xend", 32'(sc_s[4]), 32'd0);
        check("hold_sc_pre1", 32'(sc_s[5]), 32'd0);
        check("hold_sc_pre2", 32'(sc_s[6]), 32'd0);
        check("hold_sc_k7", 32'(sc_s[7]), 32'd1);
        check("hold_sc_k8", 32'(sc_s[8]), 32'd0);
        check("hold_sb_xend", 32'(sb_s[4]), 32'd1);
        check("hold_sb_pre1", 32'(sb_s[5]), 32'd1);
        check("hold_sb_pre2", 32'(sb_s[6]), 32'd0);

        // Reset during the first COL cycle of a write
        wait_idle();
        tick();
        req = 1'b1; cmd = CMD_WR; addr = 16'h4000; wdata = 8'hEE;
        tick();
        req = 1'b0;
        tick();
        check("mid_in_col", 32'(cas), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_ras", 32'(ras), 32'd1);
        check("mid_cas", 32'(cas), 32'd1);
        check("mid_we", 32'(we), 32'd1);
        check("mid_oe", 32'(oe), 32'd1);
        check("mid_rd_d", 32'(rd_d), 32'd0);
        check("mid_busy", 32'(busy), 32'd1);
        @(negedge mclk);
        reset_n = 1'b1;
        tick();
        check("mid_rel_busy_1", 32'(busy), 32'd1);
        tick();
        check("mid_rel_busy_2", 32'(busy), 32'd0);
        check("mid_rdata_clr", 32'(rdata), 32'd0);
        read_expect("r_old", 16'h4001, 8'h41);

        // Stretched timing: ROW 2 cycles, COL 4 cycles, capture on last COL edge
        while (busy2) tick();
        req2 = 1'b1; cmd2 = CMD_RD; addr2 = 16'hABCD; rd_i2 = 8'h3C;
        tick();
        req2 = 1'b0;
        ack_at = -1;
        for (int k = 0; k < 10; k++) begin
            if (ack2 && ack_at < 0) ack_at = k;
            if (k == 1) check("slow_ad_row", 32'(ad2), 32'hAB);
            if (k == 2) check("slow_ad_col", 32'(ad2), 32'hCD);
            if (k == 5) begin
                check("slow_rdata_hold", 32'(rdata2), 32'd0);
                rd_i2 = 8'h96;
            end
            tick();
        end
        check("slow_ack_at", 32'(ack_at), 32'd6);
        check("slow_rdata", 32'(rdata2), 32'h96);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
